// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM sequencing one shared ALU, register file and
// memory port through FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             overflow,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic             ext_op,
    output logic [2:0]       aluop,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    // ALU operation encoding shared with the datapath
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_retire_cnt;
    logic             r_ovf_q;

    logic       w_is_rtype;
    logic       w_r_ok;
    logic       w_is_j;
    logic       w_is_beq;
    logic       w_is_addi;
    logic       w_is_ori;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_legal;
    logic       w_ovf_chk;
    logic [2:0] w_exec_aluop;

    assign w_is_rtype = (op == OP_RTYPE);
    assign w_r_ok     = w_is_rtype &&
                        ((funct == FN_ADD)  || (funct == FN_ADDU) ||
                         (funct == FN_SUBU) || (funct == FN_AND)  ||
                         (funct == FN_OR)   || (funct == FN_SLT));
    assign w_is_j     = (op == OP_J);
    assign w_is_beq   = (op == OP_BEQ);
    assign w_is_addi  = (op == OP_ADDI);
    assign w_is_ori   = (op == OP_ORI);
    assign w_is_lw    = (op == OP_LW);
    assign w_is_sw    = (op == OP_SW);
    assign w_legal    = w_r_ok | w_is_j | w_is_beq | w_is_addi |
                        w_is_ori | w_is_lw | w_is_sw;
    // Only signed adds trap on overflow; unsigned variants always write back
    assign w_ovf_chk  = (w_is_rtype && (funct == FN_ADD)) | w_is_addi;

    // ALU operation selected in EXEC and held through WB
    always_comb begin
        w_exec_aluop = ALU_ADD;
        if (w_is_rtype) begin
            case (funct)
                FN_SUBU: w_exec_aluop = ALU_SUB;
                FN_AND:  w_exec_aluop = ALU_AND;
                FN_OR:   w_exec_aluop = ALU_OR;
                FN_SLT:  w_exec_aluop = ALU_SLT;
                default: w_exec_aluop = ALU_ADD;
            endcase
        end else if (w_is_ori) begin
            w_exec_aluop = ALU_OR;
        end else if (w_is_beq) begin
            w_exec_aluop = ALU_SUB;
        end
    end

    // State sequencing, overflow latch and retired-instruction counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_FETCH;
            r_retire_cnt <= '0;
            r_ovf_q      <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_is_j) begin
                        r_state      <= ST_FETCH;
                        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                    end else if (!w_legal) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_ovf_q <= overflow & w_ovf_chk;
                    if (w_is_beq) begin
                        r_state      <= ST_FETCH;
                        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                    end else if (w_is_lw || w_is_sw) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_sw) begin
                            r_state      <= ST_FETCH;
                            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                        end else begin
                            r_state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    r_state      <= ST_FETCH;
                    r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Control outputs decoded from the current state; forced low during reset
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        aluop      = 3'b000;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        if (reset) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_is_j) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end else if (!w_legal) begin
                        illegal = 1'b1;
                    end
                end
                ST_EXEC: begin
                    aluop = w_exec_aluop;
                    if (w_is_beq) begin
                        pc_src   = 2'd1;
                        pc_write = zero;
                    end else if (!w_is_rtype) begin
                        alu_src = 1'b1;
                        ext_op  = ~w_is_ori;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_sw;
                    aluop    = ALU_ADD;
                end
                ST_WB: begin
                    reg_write  = ~r_ovf_q;
                    reg_dst    = w_is_rtype;
                    mem_to_reg = w_is_lw;
                    aluop      = w_exec_aluop;
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed instruction sequences against a per-instruction cycle
// schedule model of mc_ctrl, checked every cycle, plus literal CPI/count pins.
`timescale 1ns/1ps
module tb_mc_ctrl;

    localparam int unsigned CW = 4;

    localparam logic [2:0] A_AND = 3'b000;
    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b110;
    localparam logic [2:0] A_SLT = 3'b111;

    localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_ILL = 5;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic       ext_op;
        logic [2:0] aluop;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
        logic [2:0] st;
    } ovec_t;

    logic clock, reset;
    logic [5:0] op, funct;
    logic zero, overflow, imem_ready, dmem_ready;
    logic imem_req, ir_write, pc_write, alu_src, ext_op;
    logic dmem_req, dmem_we, reg_dst, mem_to_reg, reg_write, illegal;
    logic [1:0] pc_src;
    logic [2:0] aluop, state;
    logic [CW-1:0] retire_cnt;

    ovec_t act;
    ovec_t e_vec;
    logic e_valid;
    logic [CW-1:0] m_cnt;
    int checks, errors;
    int cyc;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .overflow(overflow),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src(alu_src), .ext_op(ext_op), .aluop(aluop),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
        .state(state), .retire_cnt(retire_cnt)
    );

    assign act = {imem_req, ir_write, pc_write, pc_src, alu_src, ext_op, aluop,
                  dmem_req, dmem_we, reg_dst, mem_to_reg, reg_write, illegal, state};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Per-cycle comparison of all outputs against the scheduled expectation
    always @(negedge clock) begin
        if (e_valid) begin
            checks++;
            if (act !== e_vec) begin
                errors++;
                $display("FAIL outs cyc=%0d: got %h required %h", cyc, act, e_vec);
            end
            checks++;
            if (retire_cnt !== m_cnt) begin
                errors++;
                $display("FAIL retire_cnt cyc=%0d: got %0d required %0d", cyc, retire_cnt, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic int cat(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:   return (f == 6'h20 || f == 6'h21 || f == 6'h23 || f == 6'h24 ||
                             f == 6'h25 || f == 6'h2A) ? C_ALU : C_ILL;
            6'h08, 6'h0D: return C_ALU;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h02:   return C_J;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] exp_aluop(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h23:   return A_SUB;
                6'h24:   return A_AND;
                6'h25:   return A_OR;
                6'h2A:   return A_SLT;
                default: return A_ADD;
            endcase
        end
        if (o == 6'h0D) return A_OR;
        if (o == 6'h04) return A_SUB;
        return A_ADD;
    endfunction

    // One clock cycle: drive ready inputs, publish expectation, advance
    task automatic step(input ovec_t e, input logic imr, input logic dmr);
        imem_ready = imr;
        dmem_ready = dmr;
        e_vec      = e;
        e_valid    = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Run one instruction, checking each cycle against its expected schedule
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int iw, input int dw, input logic z,
                             input logic ov, input int abort_at, output int cycles);
        ovec_t e;
        int c;
        logic eff_ovf;
        c = cat(o, f);
        cycles = 0;
        op = o; funct = f; zero = z; overflow = ov;
        for (int i = 0; i < iw; i++) begin
            e = '0; e.imem_req = 1'b1;
            step(e, 1'b0, 1'b1); cycles++;
        end
        e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(e, 1'b1, 1'b0); cycles++;
        e = '0; e.st = 3'd1;
        if (c == C_J) begin
            e.pc_write = 1'b1; e.pc_src = 2'd2;
            step(e, 1'b1, 1'b1); cycles++; m_cnt++;
            return;
        end
        if (c == C_ILL) begin
            e.illegal = 1'b1;
            step(e, 1'b1, 1'b1); cycles++;
            return;
        end
        step(e, 1'b1, 1'b1); cycles++;
        e = '0; e.st = 3'd2; e.aluop = exp_aluop(o, f);
        if (c == C_BEQ) begin
            e.pc_src = 2'd1; e.pc_write = z;
            step(e, 1'b1, 1'b1); cycles++; m_cnt++;
            return;
        end
        if (o != 6'h00) begin
            e.alu_src = 1'b1;
            e.ext_op  = (o != 6'h0D);
        end
        step(e, 1'b1, 1'b1); cycles++;
        eff_ovf = ov & ((o == 6'h00 && f == 6'h20) || o == 6'h08);
        if (c == C_LW || c == C_SW) begin
            for (int i = 0; i <= dw; i++) begin
                if (abort_at != 0 && i == abort_at) return;
                e = '0; e.st = 3'd3; e.dmem_req = 1'b1; e.dmem_we = (c == C_SW); e.aluop = A_ADD;
                step(e, 1'b1, (i == dw)); cycles++;
            end
            if (c == C_SW) begin
                m_cnt++;
                return;
            end
        end
        e = '0; e.st = 3'd4; e.reg_write = ~eff_ovf; e.reg_dst = (o == 6'h00);
        e.mem_to_reg = (c == C_LW); e.aluop = exp_aluop(o, f);
        step(e, 1'b1, 1'b1); cycles++; m_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0;
        e_valid = 1'b0; m_cnt = '0;
        reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;

        // Outputs gated low while held in reset, even with readies high
        @(posedge clock); #1;
        e_vec = '0; e_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0, 0, n); chk("cpi_addu", n, 4);
        chk("cnt_after_addu", int'(retire_cnt), 1);
        run_instr(6'h00, 6'h20, 0, 0, 1'b0, 1'b1, 0, n); chk("cpi_add_ovf", n, 4);
        chk("cnt_after_add_ovf", int'(retire_cnt), 2);
        run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b1, 0, n);
        run_instr(6'h00, 6'h23, 1, 0, 1'b1, 1'b0, 0, n); chk("cpi_subu_iwait1", n, 5);
        run_instr(6'h00, 6'h24, 0, 0, 1'b0, 1'b0, 0, n);
        run_instr(6'h00, 6'h25, 0, 0, 1'b0, 1'b0, 0, n);
        run_instr(6'h00, 6'h2A, 0, 0, 1'b0, 1'b0, 0, n);
        run_instr(6'h08, 6'h11, 0, 0, 1'b0, 1'b1, 0, n);
        run_instr(6'h0D, 6'h20, 2, 0, 1'b0, 1'b1, 0, n); chk("cpi_ori_iwait2", n, 6);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0, 0, n); chk("cpi_lw_dwait3", n, 8);
        run_instr(6'h2B, 6'h00, 0, 0, 1'b0, 1'b0, 0, n); chk("cpi_sw", n, 4);
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0, 0, n); chk("cpi_beq_taken", n, 3);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0, 0, n); chk("cpi_beq_not", n, 3);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, 0, n); chk("cpi_j", n, 2);
        chk("cnt_before_illegal", int'(retire_cnt), 14);
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0, 0, n); chk("cpi_ill_op", n, 2);
        run_instr(6'h00, 6'h00, 0, 0, 1'b0, 1'b0, 0, n); chk("cpi_ill_funct", n, 2);
        run_instr(6'h00, 6'h22, 0, 0, 1'b0, 1'b0, 0, n);
        chk("cnt_after_illegal", int'(retire_cnt), 14);

        // Asynchronous reset in the middle of a stalled load
        run_instr(6'h23, 6'h00, 0, 10, 1'b0, 1'b0, 2, n);
        e_valid = 1'b0;
        #2;
        chk("mid_mem_dmem_req_pre", int'(dmem_req), 1);
        reset = 1'b0;
        #1;
        chk("rst_dmem_req", int'(dmem_req), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_retire_cnt", int'(retire_cnt), 0);
        m_cnt = '0;
        @(posedge clock); #1;
        reset = 1'b1;

        // Sixteen jumps wrap the 4-bit counter back to zero
        for (int k = 0; k < 15; k++) run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, 0, n);
        chk("cnt_15", int'(retire_cnt), 15);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, 0, n);
        chk("cnt_wrap", int'(retire_cnt), 0);
        run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0, 0, n);
        chk("cnt_after_wrap", int'(retire_cnt), 1);

        e_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
